// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants for the UART command-frame parser: header defaults,
// error codes reported on err_code, and the parser state encoding.
package uart_cmd_parser_pkg;

    localparam logic [7:0] HDR0_DEF = 8'h55;
    localparam logic [7:0] HDR1_DEF = 8'hAA;

    localparam logic [1:0] ERR_CHK = 2'd0;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_TO  = 2'd2;
    localparam logic [1:0] ERR_OVF = 2'd3;

    typedef enum logic [2:0] {
        ST_HUNT0,
        ST_HUNT1,
        ST_CMD,
        ST_LEN,
        ST_PLD,
        ST_CHK
    } state_e;

endpackage

// File: rtl/uart_fifo_rd_eng.sv
// RX FIFO read engine: one outstanding read at a time, data presented
// with byte_val the cycle after the read request.
module uart_fifo_rd_eng (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       rx_fifo_empty,
    input  logic [7:0] rx_fifo_rdata,
    output logic       rx_fifo_ren,
    output logic       byte_val,
    output logic [7:0] byte_data
);

    logic pend_q, pend_d;

    // A read already in flight completes even if ena drops meanwhile.
    always_comb begin
        rx_fifo_ren = rst && ena && !rx_fifo_empty && !pend_q;
        pend_d      = rx_fifo_ren;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend_q <= 1'b0;
        else      pend_q <= pend_d;
    end

    assign byte_val  = pend_q;
    assign byte_data = rx_fifo_rdata;

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame parser: HDR0 HDR1 CMD LEN PAYLOAD[LEN] CHK, streaming payload bytes
// out and pulsing cmd_val on a good frame or frm_err on an aborted one.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter logic [7:0] HDR0    = HDR0_DEF,
    parameter logic [7:0] HDR1    = HDR1_DEF,
    parameter int         MAX_LEN = 16,
    parameter int         TO_CYC  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       rx_fifo_empty,
    output logic       rx_fifo_ren,
    input  logic [7:0] rx_fifo_rdata,
    input  logic       rx_overflow,
    output logic       cmd_val,
    output logic [7:0] cmd_id,
    output logic [4:0] cmd_len,
    output logic       pld_wen,
    output logic [3:0] pld_waddr,
    output logic [7:0] pld_wdata,
    output logic       frm_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int         CNT_W     = $clog2(TO_CYC);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic       byte_val;
    logic [7:0] byte_data;

    uart_fifo_rd_eng u_rd_eng (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_rdata(rx_fifo_rdata),
        .rx_fifo_ren  (rx_fifo_ren),
        .byte_val     (byte_val),
        .byte_data    (byte_data)
    );

    state_e           state_q, state_d;
    logic [7:0]       sum_q, sum_d, cmd_q, cmd_d;
    logic [4:0]       len_q, len_d, idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             cmd_val_q, cmd_val_d, pld_wen_q, pld_wen_d;
    logic             frm_err_q, frm_err_d, busy_q, busy_d;
    logic [7:0]       cmd_id_q, cmd_id_d, pld_wdata_q, pld_wdata_d;
    logic [4:0]       cmd_len_q, cmd_len_d;
    logic [3:0]       pld_waddr_q, pld_waddr_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             abort;
    logic [1:0]       abort_code;

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        idx_d       = idx_q;
        ovf_d       = rx_overflow;
        cmd_val_d   = 1'b0;
        cmd_id_d    = cmd_id_q;
        cmd_len_d   = cmd_len_q;
        pld_wen_d   = 1'b0;
        pld_waddr_d = pld_waddr_q;
        pld_wdata_d = pld_wdata_q;
        frm_err_d   = 1'b0;
        err_code_d  = err_code_q;
        abort       = 1'b0;
        abort_code  = ERR_CHK;

        // Overflow beats any byte-driven outcome, which beats the timeout.
        if (rx_overflow && !ovf_q && state_q != ST_HUNT0) begin
            abort      = 1'b1;
            abort_code = ERR_OVF;
        end else if (byte_val) begin
            case (state_q)
                ST_HUNT0: if (byte_data == HDR0) state_d = ST_HUNT1;
                ST_HUNT1: begin
                    if (byte_data == HDR1)      state_d = ST_CMD;
                    else if (byte_data != HDR0) state_d = ST_HUNT0;
                end
                ST_CMD: begin
                    cmd_d   = byte_data;
                    sum_d   = byte_data;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    sum_d = sum_q + byte_data;
                    len_d = byte_data[4:0];
                    idx_d = 5'd0;
                    if (byte_data > MAX_LEN_B) begin
                        abort      = 1'b1;
                        abort_code = ERR_LEN;
                    end else if (byte_data == 8'd0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_PLD;
                    end
                end
                ST_PLD: begin
                    pld_wen_d   = 1'b1;
                    pld_waddr_d = idx_q[3:0];
                    pld_wdata_d = byte_data;
                    sum_d       = sum_q + byte_data;
                    idx_d       = idx_q + 5'd1;
                    if (idx_q == len_q - 5'd1) state_d = ST_CHK;
                end
                ST_CHK: begin
                    if (byte_data == sum_q) begin
                        cmd_val_d = 1'b1;
                        cmd_id_d  = cmd_q;
                        cmd_len_d = len_q;
                        state_d   = ST_HUNT0;
                    end else begin
                        abort      = 1'b1;
                        abort_code = ERR_CHK;
                    end
                end
                default: state_d = ST_HUNT0;
            endcase
        end else if (state_q != ST_HUNT0 && ena && cnt_q == CNT_W'(TO_CYC - 1)) begin
            abort      = 1'b1;
            abort_code = ERR_TO;
        end

        if (abort) begin
            frm_err_d  = 1'b1;
            err_code_d = abort_code;
            state_d    = ST_HUNT0;
        end

        if (byte_val || abort || state_q == ST_HUNT0) cnt_d = '0;
        else if (ena)                                 cnt_d = cnt_q + CNT_W'(1);
        else                                          cnt_d = cnt_q;

        busy_d = (state_d != ST_HUNT0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_HUNT0;
            sum_q       <= '0;
            cmd_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            cmd_val_q   <= 1'b0;
            cmd_id_q    <= '0;
            cmd_len_q   <= '0;
            pld_wen_q   <= 1'b0;
            pld_waddr_q <= '0;
            pld_wdata_q <= '0;
            frm_err_q   <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            cmd_val_q   <= cmd_val_d;
            cmd_id_q    <= cmd_id_d;
            cmd_len_q   <= cmd_len_d;
            pld_wen_q   <= pld_wen_d;
            pld_waddr_q <= pld_waddr_d;
            pld_wdata_q <= pld_wdata_d;
            frm_err_q   <= frm_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_val   = cmd_val_q;
    assign cmd_id    = cmd_id_q;
    assign cmd_len   = cmd_len_q;
    assign pld_wen   = pld_wen_q;
    assign pld_waddr = pld_waddr_q;
    assign pld_wdata = pld_wdata_q;
    assign frm_err   = frm_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a simple FIFO model feeds frames, a
// negedge monitor records strobes, and immediate assertions check results.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b1;
    logic       rx_fifo_empty;
    logic       rx_fifo_ren;
    logic [7:0] rx_fifo_rdata = 8'h00;
    logic       rx_overflow = 1'b0;
    logic       cmd_val;
    logic [7:0] cmd_id;
    logic [4:0] cmd_len;
    logic       pld_wen;
    logic [3:0] pld_waddr;
    logic [7:0] pld_wdata;
    logic       frm_err;
    logic [1:0] err_code;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_cmd_parser #(.TO_CYC(100)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_ren  (rx_fifo_ren),
        .rx_fifo_rdata(rx_fifo_rdata),
        .rx_overflow  (rx_overflow),
        .cmd_val      (cmd_val),
        .cmd_id       (cmd_id),
        .cmd_len      (cmd_len),
        .pld_wen      (pld_wen),
        .pld_waddr    (pld_waddr),
        .pld_wdata    (pld_wdata),
        .frm_err      (frm_err),
        .err_code     (err_code),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears on rdata the cycle after ren
    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic [7:0] frm [$];

    assign rx_fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rx_fifo_ren) begin
            rx_fifo_rdata <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Monitor
    int         n_cmd = 0, n_err = 0, n_wen = 0, n_consec = 0;
    logic [7:0] m_id = 8'h00;
    logic [4:0] m_len = 5'd0;
    logic [1:0] m_code = 2'd0;
    logic [3:0] wa [0:15];
    logic [7:0] wd [0:15];
    logic       prev_ren = 1'b0;

    always @(negedge clk) begin
        if (cmd_val) begin
            n_cmd++;
            m_id  = cmd_id;
            m_len = cmd_len;
        end
        if (frm_err) begin
            n_err++;
            m_code = err_code;
        end
        if (pld_wen) begin
            if (n_wen < 16) begin
                wa[n_wen] = pld_waddr;
                wd[n_wen] = pld_wdata;
            end
            n_wen++;
        end
        if (rx_fifo_ren && prev_ren) n_consec++;
        prev_ren = rx_fifo_ren;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_frm();
        foreach (frm[i]) begin
            mem[wr_ptr] = frm[i];
            wr_ptr++;
        end
    endtask

    task automatic clr_mon();
        n_cmd = 0; n_err = 0; n_wen = 0; n_consec = 0;
        m_id = 8'h00; m_len = 5'd0; m_code = 2'd0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_cmd_val"},   32'(cmd_val),   32'h0);
        check({tag, "_cmd_id"},    32'(cmd_id),    32'h0);
        check({tag, "_cmd_len"},   32'(cmd_len),   32'h0);
        check({tag, "_pld_wen"},   32'(pld_wen),   32'h0);
        check({tag, "_pld_waddr"}, 32'(pld_waddr), 32'h0);
        check({tag, "_pld_wdata"}, 32'(pld_wdata), 32'h0);
        check({tag, "_frm_err"},   32'(frm_err),   32'h0);
        check({tag, "_err_code"},  32'(err_code),  32'h0);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_ren"},       32'(rx_fifo_ren), 32'h0);
    endtask

    initial begin
        // Reset state
        run(3);
        check_zero_outputs("rst");
        rst = 1'b1;
        run(2);

        // Good frame with two payload bytes
        clr_mon();
        frm = '{8'h55, 8'hAA, 8'h10, 8'h02, 8'h11, 8'h22, 8'h45};
        push_frm();
        run(30);
        check("g1_ncmd",  32'(n_cmd), 32'd1);
        check("g1_id",    32'(m_id),  32'h10);
        check("g1_len",   32'(m_len), 32'd2);
        check("g1_nwen",  32'(n_wen), 32'd2);
        check("g1_wa0",   32'(wa[0]), 32'd0);
        check("g1_wd0",   32'(wd[0]), 32'h11);
        check("g1_wa1",   32'(wa[1]), 32'd1);
        check("g1_wd1",   32'(wd[1]), 32'h22);
        check("g1_nerr",  32'(n_err), 32'd0);
        check("g1_consec", 32'(n_consec), 32'd0);
        check("g1_cmd_id_hold", 32'(cmd_id), 32'h10);
        check("g1_busy",  32'(busy),  32'd0);

        // Bad checksum, then a zero-length good frame
        clr_mon();
        frm = '{8'h55, 8'hAA, 8'h10, 8'h02, 8'h11, 8'h22, 8'h46};
        push_frm();
        run(30);
        check("chk_ncmd", 32'(n_cmd),  32'd0);
        check("chk_nerr", 32'(n_err),  32'd1);
        check("chk_code", 32'(m_code), 32'd0);
        clr_mon();
        frm = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h01};
        push_frm();
        run(30);
        check("z_ncmd", 32'(n_cmd), 32'd1);
        check("z_id",   32'(m_id),  32'h01);
        check("z_len",  32'(m_len), 32'd0);
        check("z_nerr", 32'(n_err), 32'd0);

        // Resync on repeated HDR0, then oversized LEN
        clr_mon();
        frm = '{8'h55, 8'h55, 8'hAA, 8'h03, 8'h00, 8'h03};
        push_frm();
        run(30);
        check("rs_ncmd", 32'(n_cmd), 32'd1);
        check("rs_id",   32'(m_id),  32'h03);
        check("rs_len",  32'(m_len), 32'd0);
        clr_mon();
        frm = '{8'h55, 8'hAA, 8'h05, 8'h11};
        push_frm();
        run(30);
        check("len_nerr", 32'(n_err),  32'd1);
        check("len_code", 32'(m_code), 32'd1);
        check("len_ncmd", 32'(n_cmd),  32'd0);
        check("len_busy", 32'(busy),   32'd0);

        // Inter-byte timeout
        clr_mon();
        frm = '{8'h55, 8'hAA, 8'h07};
        push_frm();
        run(40);
        check("to_busy_mid", 32'(busy),  32'd1);
        check("to_nerr_mid", 32'(n_err), 32'd0);
        run(110);
        check("to_nerr", 32'(n_err),  32'd1);
        check("to_code", 32'(m_code), 32'd2);
        check("to_busy", 32'(busy),   32'd0);

        // ena low mid-frame holds the timer; frame completes afterwards
        clr_mon();
        frm = '{8'h55, 8'hAA, 8'h07};
        push_frm();
        run(10);
        ena = 1'b0;
        run(500);
        check("en_nerr", 32'(n_err), 32'd0);
        check("en_busy", 32'(busy),  32'd1);
        ena = 1'b1;
        frm = '{8'h01, 8'hAB, 8'hB3};
        push_frm();
        run(30);
        check("en_ncmd", 32'(n_cmd), 32'd1);
        check("en_id",   32'(m_id),  32'h07);
        check("en_len",  32'(m_len), 32'd1);
        check("en_wd0",  32'(wd[0]), 32'hAB);
        check("en_nerr2", 32'(n_err), 32'd0);

        // Overflow during payload
        clr_mon();
        frm = '{8'h55, 8'hAA, 8'h09, 8'h04, 8'h01, 8'h02};
        push_frm();
        run(20);
        check("ovf_busy_mid", 32'(busy), 32'd1);
        rx_overflow = 1'b1;
        run(1);
        rx_overflow = 1'b0;
        run(5);
        check("ovf_nerr", 32'(n_err),  32'd1);
        check("ovf_code", 32'(m_code), 32'd3);
        check("ovf_nwen", 32'(n_wen),  32'd2);
        check("ovf_busy", 32'(busy),   32'd0);

        // Overflow toggling in HUNT0 is ignored
        clr_mon();
        rx_overflow = 1'b1; run(2);
        rx_overflow = 1'b0; run(2);
        rx_overflow = 1'b1; run(2);
        rx_overflow = 1'b0; run(4);
        check("h0ovf_nerr", 32'(n_err),    32'd0);
        check("h0ovf_code", 32'(err_code), 32'd3);

        // Reset while in PLD, then a good frame
        clr_mon();
        frm = '{8'h55, 8'hAA, 8'h0A, 8'h03, 8'h01, 8'h02};
        push_frm();
        run(20);
        check("mr_busy_pre", 32'(busy),      32'd1);
        check("mr_wa_pre",   32'(pld_waddr), 32'd1);
        rst = 1'b0;
        run(1);
        check_zero_outputs("mr");
        rst = 1'b1;
        run(2);
        clr_mon();
        frm = '{8'h55, 8'hAA, 8'h0B, 8'h01, 8'h5A, 8'h66};
        push_frm();
        run(30);
        check("pr_ncmd", 32'(n_cmd), 32'd1);
        check("pr_id",   32'(m_id),  32'h0B);
        check("pr_len",  32'(m_len), 32'd1);
        check("pr_wd0",  32'(wd[0]), 32'h5A);
        check("pr_nerr", 32'(n_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
